// File: rtl/lcd_cmd_arbiter_pkg.sv
// Shared definitions for the two-requester lcd_ctrl command arbiter:
// command codes, FSM state encoding and default image/window sizes.
package lcd_pkg;

    localparam logic [2:0] CMD_REFLASH = 3'd0;
    localparam logic [2:0] CMD_LOAD    = 3'd1;
    localparam logic [2:0] CMD_SHR     = 3'd2;
    localparam logic [2:0] CMD_SHL     = 3'd3;
    localparam logic [2:0] CMD_SHU     = 3'd4;
    localparam logic [2:0] CMD_SHD     = 3'd5;

    localparam int IMG_PIX_DEF = 36;
    localparam int WIN_PIX_DEF = 9;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_COLLECT
    } state_t;

    // Codes above the last shift command have no meaning to lcd_ctrl.
    function automatic logic cmd_is_legal(input logic [2:0] cmd);
        return (cmd <= CMD_SHD);
    endfunction

endpackage

// File: rtl/lcd_cmd_arbiter_rr_pick.sv
// Two-way round-robin picker: when both requesters are valid the pointer
// decides, otherwise the lone valid requester wins.
module lcd_rr_pick (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       win
);

    // Select the winner index and expand it to a one-hot grant.
    always_comb begin
        win   = 1'b0;
        grant = 2'b00;
        case (valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ptr;
            default: win = 1'b0;
        endcase
        if (valid != 2'b00) begin
            grant = win ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Shares one lcd_ctrl between two command sources. One command is in
// flight at a time: it is issued, the 6x6 image is streamed for loads,
// and the 3x3 output window is routed back to whoever owns the grant.
module lcd_cmd_arbiter
    import lcd_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int IMG_PIX = IMG_PIX_DEF,
    parameter int WIN_PIX = WIN_PIX_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [2:0]        req_cmd0,
    input  logic [2:0]        req_cmd1,
    output logic [1:0]        req_ready,
    output logic [1:0]        ld_pull,
    input  logic [DATA_W-1:0] ld_data0,
    input  logic [DATA_W-1:0] ld_data1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_done,
    output logic [1:0]        rsp_err,
    output logic [2:0]        lcd_cmd,
    output logic              lcd_cmd_valid,
    output logic [DATA_W-1:0] lcd_datain,
    input  logic              lcd_busy,
    input  logic [DATA_W-1:0] lcd_dataout,
    input  logic              lcd_output_valid,
    output logic              owner,
    output logic              active
);

    localparam int PIX_W = $clog2(IMG_PIX);
    localparam int WIN_W = $clog2(WIN_PIX);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(IMG_PIX - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_PIX - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                owner_q, owner_d;
    logic [2:0]          cmd_q, cmd_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W-1:0]   datain_q, datain_d;
    logic [1:0]          err_q, err_d;

    logic [1:0]          arb_valid;
    logic [1:0]          grant;
    logic                win;
    logic [2:0]          sel_cmd;
    logic                sel_legal;
    logic [1:0]          owner_oh;
    logic                pulling;
    logic                win_last;
    logic                tmo_hit;
    logic [DATA_W-1:0]   ld_byte;

    // Arbitration is only offered while idle and lcd_ctrl is free.
    assign arb_valid = (state_q == ST_IDLE && !lcd_busy) ? req_valid : 2'b00;

    lcd_rr_pick u_pick (
        .valid (arb_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .win   (win)
    );

    assign sel_cmd   = win ? req_cmd1 : req_cmd0;
    assign sel_legal = cmd_is_legal(sel_cmd);
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;
    assign ld_byte   = owner_q ? ld_data1 : ld_data0;
    // The ISSUE cycle of a load already pulls byte 0, LOAD pulls the rest.
    assign pulling   = (state_q == ST_ISSUE && cmd_q == CMD_LOAD) || (state_q == ST_LOAD);
    assign win_last  = (state_q == ST_COLLECT) && lcd_output_valid && (win_cnt_q == WIN_LAST);
    assign tmo_hit   = (state_q == ST_COLLECT) && !lcd_output_valid && (tmo_cnt_q == TMO_LIMIT);

    // State and datapath registers, all cleared at once by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            cmd_q     <= 3'd0;
            pix_cnt_q <= '0;
            win_cnt_q <= '0;
            tmo_cnt_q <= '0;
            datain_q  <= '0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            pix_cnt_q <= pix_cnt_d;
            win_cnt_q <= win_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            datain_q  <= datain_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: grant, issue, stream the image, collect the window.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        pix_cnt_d = pix_cnt_q;
        win_cnt_d = win_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        err_d     = 2'b00;
        datain_d  = pulling ? ld_byte : datain_q;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    if (!sel_legal) begin
                        // Swallow the bad command and let the other side go next.
                        err_d    = grant;
                        rr_ptr_d = ~win;
                    end else begin
                        cmd_d   = sel_cmd;
                        owner_d = win;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                win_cnt_d = '0;
                tmo_cnt_d = '0;
                if (cmd_q == CMD_LOAD) begin
                    // Byte 0 is pulled in this cycle, so LOAD resumes at index 1.
                    pix_cnt_d = PIX_W'(1);
                    state_d   = ST_LOAD;
                end else begin
                    state_d   = ST_COLLECT;
                end
            end
            ST_LOAD: begin
                if (pix_cnt_q == PIX_LAST) begin
                    win_cnt_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = ST_COLLECT;
                end else begin
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                end
            end
            ST_COLLECT: begin
                if (lcd_output_valid) begin
                    tmo_cnt_d = '0;
                    if (win_last) begin
                        rr_ptr_d = ~owner_q;
                        state_d  = ST_IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                    end
                end else if (tmo_hit) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; responses pass straight through while collecting.
    always_comb begin
        req_ready     = reset ? 2'b00 : grant;
        lcd_cmd_valid = (state_q == ST_ISSUE);
        ld_pull       = pulling ? owner_oh : 2'b00;
        rsp_valid     = (state_q == ST_COLLECT && lcd_output_valid) ? owner_oh : 2'b00;
        rsp_data      = (state_q == ST_COLLECT) ? lcd_dataout : '0;
        rsp_done      = win_last ? owner_oh : 2'b00;
        rsp_err       = err_q | (tmo_hit ? owner_oh : 2'b00);
        lcd_cmd       = cmd_q;
        lcd_datain    = datain_q;
        owner         = owner_q;
        active        = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter. The bench plays both requesters and
// the lcd_ctrl output side; expected response bytes go into a scoreboard
// queue when the fake lcd_ctrl emits them and are checked on delivery.
module tb_lcd_cmd_arbiter;

    typedef struct {
        logic [1:0] vld;
        logic [1:0] done;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] req_valid;
    logic [2:0] req_cmd0;
    logic [2:0] req_cmd1;
    logic [1:0] req_ready;
    logic [1:0] ld_pull;
    logic [7:0] ld_data0;
    logic [7:0] ld_data1;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_done;
    logic [1:0] rsp_err;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] lcd_datain;
    logic       lcd_busy;
    logic [7:0] lcd_dataout;
    logic       lcd_output_valid;
    logic       owner;
    logic       active;

    logic [7:0] pull_cnt0;
    logic [7:0] pull_cnt1;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    lcd_cmd_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_cmd0         (req_cmd0),
        .req_cmd1         (req_cmd1),
        .req_ready        (req_ready),
        .ld_pull          (ld_pull),
        .ld_data0         (ld_data0),
        .ld_data1         (ld_data1),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_done         (rsp_done),
        .rsp_err          (rsp_err),
        .lcd_cmd          (lcd_cmd),
        .lcd_cmd_valid    (lcd_cmd_valid),
        .lcd_datain       (lcd_datain),
        .lcd_busy         (lcd_busy),
        .lcd_dataout      (lcd_dataout),
        .lcd_output_valid (lcd_output_valid),
        .owner            (owner),
        .active           (active)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester image sources: each presents pixel index 0..35 and advances on every pull.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pull_cnt0 <= 8'd0;
            pull_cnt1 <= 8'd0;
        end else begin
            if (ld_pull[0]) pull_cnt0 <= (pull_cnt0 == 8'd35) ? 8'd0 : pull_cnt0 + 8'd1;
            if (ld_pull[1]) pull_cnt1 <= (pull_cnt1 == 8'd35) ? 8'd0 : pull_cnt1 + 8'd1;
        end
    end

    assign ld_data0 = pull_cnt0;
    assign ld_data1 = 8'h80 | pull_cnt1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [2:0] c0, input logic [2:0] c1);
        req_valid = v;
        req_cmd0  = c0;
        req_cmd1  = c1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Fake lcd_ctrl output: nine bytes, each queued as the expected response.
    task automatic emitWindow(input int req, input logic [7:0] base, input bit gap);
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            tick();
            lcd_output_valid = 1'b1;
            lcd_dataout      = base + 8'(i);
            e.vld  = (req == 1) ? 2'b10 : 2'b01;
            e.done = (i == 8) ? e.vld : 2'b00;
            e.data = lcd_dataout;
            exp_q.push_back(e);
            if (gap) begin
                tick();
                lcd_output_valid = 1'b0;
            end
        end
        if (!gap) begin
            tick();
            lcd_output_valid = 1'b0;
        end
    endtask

    // Requester 0 load from an idle arbiter: 36 pulls, lagged datain, then a window.
    task automatic runLoad(input logic [7:0] base);
        tick();
        applyStimulus(2'b01, 3'd1, 3'd0);
        settle();
        checkOutput("load_ready", req_ready, 2'b01);
        tick();
        applyStimulus(2'b00, 3'd0, 3'd0);
        settle();
        checkOutput("load_cmd_valid", lcd_cmd_valid, 1'b1);
        checkOutput("load_cmd", lcd_cmd, 3'd1);
        checkOutput("load_pull0", ld_pull, 2'b01);
        checkOutput("load_owner", owner, 1'b0);
        for (int k = 1; k < 36; k++) begin
            tick();
            settle();
            checkOutput("load_pull", ld_pull, 2'b01);
            checkOutput("load_datain", lcd_datain, 32'(k - 1));
        end
        tick();
        settle();
        checkOutput("load_pull_end", ld_pull, 2'b00);
        checkOutput("load_datain_last", lcd_datain, 8'd35);
        checkOutput("load_active", active, 1'b1);
        emitWindow(0, base, 1'b1);
        settle();
        checkOutput("load_idle", active, 1'b0);
        checkOutput("load_datain_hold", lcd_datain, 8'd35);
    endtask

    // Scoreboard sink: every delivered byte must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                checkOutput("rsp_unexpected", {rsp_valid, rsp_done, rsp_data}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_byte", {rsp_valid, rsp_done, rsp_data}, {e.vld, e.done, e.data});
            end
        end
    end

    // Directed sequence.
    initial begin
        reset            = 1'b1;
        lcd_busy         = 1'b0;
        lcd_dataout      = 8'h00;
        lcd_output_valid = 1'b0;
        applyStimulus(2'b00, 3'd0, 3'd0);
        #2;
        checkOutput("rst_active", active, 1'b0);
        checkOutput("rst_owner", owner, 1'b0);
        checkOutput("rst_cmd_valid", lcd_cmd_valid, 1'b0);
        checkOutput("rst_datain", lcd_datain, 8'h00);
        checkOutput("rst_err", rsp_err, 2'b00);
        tick();
        reset = 1'b0;

        $display("[TB] both requesters reflash, order 0,1,0,1");
        tick();
        applyStimulus(2'b11, 3'd0, 3'd0);
        for (int r = 0; r < 4; r++) begin
            settle();
            checkOutput("rr_ready", req_ready, (r % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            settle();
            checkOutput("rr_cmd_valid", lcd_cmd_valid, 1'b1);
            checkOutput("rr_owner", owner, 32'(r % 2));
            checkOutput("rr_no_pull", ld_pull, 2'b00);
            emitWindow(r % 2, 8'h20 + 8'(r * 16), 1'b0);
        end
        applyStimulus(2'b00, 3'd0, 3'd0);

        $display("[TB] requester 0 load");
        runLoad(8'h40);

        $display("[TB] requester 1 illegal command");
        tick();
        applyStimulus(2'b10, 3'd0, 3'd6);
        settle();
        checkOutput("ill_ready", req_ready, 2'b10);
        checkOutput("ill_err_early", rsp_err, 2'b00);
        tick();
        applyStimulus(2'b00, 3'd0, 3'd0);
        settle();
        checkOutput("ill_err", rsp_err, 2'b10);
        checkOutput("ill_cmd_valid", lcd_cmd_valid, 1'b0);
        checkOutput("ill_active", active, 1'b0);
        tick();
        settle();
        checkOutput("ill_err_clear", rsp_err, 2'b00);
        checkOutput("ill_cmd_valid2", lcd_cmd_valid, 1'b0);

        $display("[TB] busy blocks grant, then shift-right times out");
        tick();
        lcd_busy = 1'b1;
        applyStimulus(2'b01, 3'd2, 3'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput("busy_ready", req_ready, 2'b00);
            tick();
        end
        lcd_busy = 1'b0;
        settle();
        checkOutput("busy_release_ready", req_ready, 2'b01);
        tick();
        applyStimulus(2'b00, 3'd0, 3'd0);
        settle();
        checkOutput("shr_cmd_valid", lcd_cmd_valid, 1'b1);
        checkOutput("shr_cmd", lcd_cmd, 3'd2);
        checkOutput("shr_no_pull", ld_pull, 2'b00);
        tick();
        settle();
        checkOutput("tmo_entry_active", active, 1'b1);
        for (int i = 1; i < 64; i++) begin
            tick();
            settle();
            checkOutput("tmo_wait_err", rsp_err, 2'b00);
        end
        tick();
        settle();
        checkOutput("tmo_err", rsp_err, 2'b01);
        tick();
        settle();
        checkOutput("tmo_idle", active, 1'b0);
        checkOutput("tmo_err_clear", rsp_err, 2'b00);
        tick();
        lcd_output_valid = 1'b1;
        lcd_dataout      = 8'hEE;
        settle();
        checkOutput("stray_rsp_valid", rsp_valid, 2'b00);
        tick();
        lcd_output_valid = 1'b0;

        $display("[TB] reset during load, then full reload");
        tick();
        applyStimulus(2'b01, 3'd1, 3'd0);
        tick();
        applyStimulus(2'b00, 3'd0, 3'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
        end
        settle();
        checkOutput("abort_datain", lcd_datain, 8'd19);
        reset = 1'b1;
        #1;
        checkOutput("abort_pull", ld_pull, 2'b00);
        checkOutput("abort_active", active, 1'b0);
        checkOutput("abort_datain_rst", lcd_datain, 8'h00);
        checkOutput("abort_cmd", lcd_cmd, 3'd0);
        checkOutput("abort_owner", owner, 1'b0);
        tick();
        reset = 1'b0;
        runLoad(8'h90);

        tick();
        checkOutput("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_arbiter.md
Name: lcd_cmd_arbiter

Overview:
- Two-requester round-robin arbiter that shares one lcd_ctrl instance between two command sources.
- Issues one command at a time and streams the 36-byte image for load (cmd 1).
- Collects the 9-byte 3x3 output window and routes it back to the owning requester.
- Sits between host-side command sources and lcd_ctrl; holds no image storage.

Parameters:
- DATA_W, 8, pixel/byte width
- IMG_PIX, 36, bytes streamed per load command (6x6)
- WIN_PIX, 9, output bytes per command (3x3)
- TIMEOUT, 64, max cycles in COLLECT before abort

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester command request
- req_cmd0, req_cmd1  in  3 each  command of requester 0/1
- req_ready  out  2  command accepted this cycle; one-hot or zero
- ld_pull  out  2  requester must present the next image byte this cycle
- ld_data0, ld_data1  in  DATA_W each  image byte, sampled when ld_pull bit is high
- rsp_valid  out  2  output byte valid for requester i
- rsp_data  out  DATA_W  output byte, shared by both requesters
- rsp_done  out  2  pulse on the 9th byte of a command
- rsp_err  out  2  pulse on illegal command or timeout
- lcd_cmd  out  3  command to lcd_ctrl
- lcd_cmd_valid  out  1  command strobe to lcd_ctrl
- lcd_datain  out  DATA_W  image byte to lcd_ctrl
- lcd_busy  in  1  lcd_ctrl busy
- lcd_dataout  in  DATA_W  lcd_ctrl output byte
- lcd_output_valid  in  1  lcd_ctrl output strobe
- owner  out  1  index of the current grant holder
- active  out  1  grant held (state != IDLE)

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; counters 0.
- Legal commands are 0-5 (0 reflash, 1 load, 2-5 shifts). Commands 6 and 7 are illegal.
- States: IDLE, ISSUE, LOAD, COLLECT.
- IDLE:
  - Arbitration occurs only when lcd_busy=0 and some req_valid bit is high.
  - If both requesters are valid, the winner is rr_ptr; otherwise the single valid requester wins.
  - req_ready[w]=1 combinationally in the same cycle. Transfer happens on req_valid&req_ready.
  - Illegal command from winner: accept it, pulse rsp_err[w] next cycle, set rr_ptr=~w, stay IDLE. Nothing is sent to lcd_ctrl.
  - Legal command: register lcd_cmd, owner=w, go to ISSUE.
- ISSUE (1 cycle):
  - lcd_cmd_valid=1.
  - If cmd==1: ld_pull[owner]=1, pix_cnt=0 and the byte is captured. Next state is LOAD.
  - Otherwise next state is COLLECT.
- LOAD:
  - ld_pull[owner]=1 every cycle; byte captured into lcd_datain on the clock edge.
  - lcd_datain therefore lags ld_pull by 1 cycle. The first byte appears the cycle after lcd_cmd_valid.
  - Exactly IMG_PIX pulls total, including the ISSUE cycle. Go to COLLECT after pull index 35.
  - lcd_datain holds its last value outside load.
- COLLECT:
  - rsp_valid[owner]=lcd_output_valid and rsp_data=lcd_dataout, combinational, zero latency.
  - win_cnt counts lcd_output_valid. On the WIN_PIX-th byte: rsp_done[owner] pulses in the same cycle, rr_ptr=~owner, go to IDLE.
  - tmo_cnt starts at 0 on COLLECT entry and is cleared by each output byte. On reaching TIMEOUT: rsp_err[owner] pulses, rr_ptr=~owner, go to IDLE.
- lcd_output_valid outside COLLECT is dropped; rsp_valid stays 0.
- A requester losing arbitration keeps req_valid high; it is served at the next IDLE with lcd_busy=0.
- Asserting reset in any state clears all of the above at once. A partial load is abandoned, and the next command after reset starts cleanly from IDLE.

Decomposition:
- Package lcd_pkg holds:
  - Command codes: CMD_REFLASH=0, CMD_LOAD=1, CMD_SHR=2, CMD_SHL=3, CMD_SHU=4, CMD_SHD=5.
  - The state enum.
  - IMG_PIX and WIN_PIX defaults.
- One sub-module, lcd_rr_pick: a 2-way round-robin picker. Inputs are valid[1:0] and ptr; outputs are grant one-hot and win index.

Test Plan:
1. Req0 load only, ld_data0=pixel index 0..35 -> 36 ld_pull[0] cycles, then lcd_datain=0..35 on consecutive cycles starting one cycle after lcd_cmd_valid. Model returns 9 bytes -> rsp_valid[0] x9, rsp_done[0] on the 9th.
2. Both requesters assert reflash (cmd 0) together, rr_ptr=0 -> req0 served first, then req1 at the next IDLE. Repeat with both requesters -> order alternates 0,1,0,1.
3. Req1 sends cmd 6 -> req_ready[1]=1 and rsp_err[1] next cycle; lcd_cmd_valid never asserts.
4. lcd_busy held high -> req_ready stays 0. Release busy -> grant in the same cycle.
5. Model never outputs after shift-right (cmd 2) -> rsp_err[owner] at COLLECT entry+64 cycles, then IDLE. Also verify stray lcd_output_valid in IDLE gives rsp_valid=0.
6. Reset asserted at load byte 20 -> all outputs 0 immediately. After release, a new load streams the full 36 bytes.
